// File: rtl/frame_assembler.sv
// frame_assembler: hunts for a sync byte, collects a 32-byte coefficient frame and
// publishes the 8 words only when the trailing XOR checksum matches.
module frame_assembler #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] zero_in_0,
    output logic [31:0] zero_in_1,
    output logic [31:0] zero_in_2,
    output logic [31:0] zero_in_3,
    output logic [31:0] pole_in_0,
    output logic [31:0] pole_in_1,
    output logic [31:0] pole_in_2,
    output logic [31:0] pole_in_3,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, DONE} state_t;
    state_t state, next_state;

    logic [4:0]    cnt;
    logic [TW-1:0] tmo;
    logic [7:0]    acc;
    logic [255:0]  work, held;
    logic          hs, tmo_hit, good, done_d, err_d;

    assign hs      = in_valid && in_ready;
    assign tmo_hit = !hs && tmo == TMO_LAST && (state == PAYLOAD || state == CHECK);
    assign good    = state == CHECK && hs && in_data == acc;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= HUNT;
        else        state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            HUNT:    next_state = (hs && in_data == SYNC_BYTE) ? PAYLOAD : HUNT;
            PAYLOAD: next_state = (hs && cnt == 5'd31) ? CHECK : tmo_hit ? DONE : PAYLOAD;
            CHECK:   next_state = (hs || tmo_hit) ? DONE : CHECK;
            default: next_state = HUNT;
        endcase
    end

    always_comb begin
        done_d = good;
        err_d  = (state == CHECK && hs && in_data != acc) || tmo_hit;
        busy   = state != HUNT;
    end

    // in_ready is registered from next_state so it is low exactly in DONE and in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= '0;
            tmo        <= '0;
            acc        <= '0;
            work       <= '0;
            held       <= '0;
        end else begin
            in_ready   <= next_state != DONE;
            frame_done <= done_d;
            frame_err  <= err_d;
            tmo        <= (state == HUNT || state == DONE || hs) ? '0 : tmo + 1'b1;
            if (state == HUNT && hs && in_data == SYNC_BYTE) begin
                acc <= '0;
                cnt <= '0;
            end
            if (state == PAYLOAD && hs) begin
                work[{cnt, 3'b000} +: 8] <= in_data;
                acc                      <= acc ^ in_data;
                cnt                      <= cnt + 1'b1;
            end
            if (good) held <= work;
        end
    end

    assign zero_in_0 = held[31:0];
    assign zero_in_1 = held[63:32];
    assign zero_in_2 = held[95:64];
    assign zero_in_3 = held[127:96];
    assign pole_in_0 = held[159:128];
    assign pole_in_1 = held[191:160];
    assign pole_in_2 = held[223:192];
    assign pole_in_3 = held[255:224];
endmodule

// File: tb/tb_frame_assembler.sv
// tb_frame_assembler: directed frames with a scoreboard of expected done/err pulses
// checked by an independent monitor on the falling edge.
module tb_frame_assembler;
    localparam int TIMEOUT_CYC = 1024;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 0, reset = 0, in_valid = 0, in_ready;
    logic [7:0]  in_data = 0;
    logic [31:0] z0, z1, z2, z3, p0, p1, p2, p3;
    logic        frame_done, frame_err, busy;
    logic [255:0] outs, model_w;
    logic [7:0]  pay [32];
    int          checks = 0, errors = 0;

    typedef struct packed {logic err; logic [255:0] w;} exp_t;
    exp_t q[$];

    frame_assembler #(.SYNC_BYTE(SYNC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .zero_in_0(z0), .zero_in_1(z1), .zero_in_2(z2), .zero_in_3(z3),
        .pole_in_0(p0), .pole_in_1(p1), .pole_in_2(p2), .pole_in_3(p3),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    assign outs = {p3, p2, p1, p0, z3, z2, z1, z0};
    always #5 clk = ~clk;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset && (frame_done || frame_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual done=%b err=%b required none", frame_done, frame_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", {254'd0, frame_err, frame_done}, e.err ? 256'd2 : 256'd1);
                chk("pulse_words", outs, e.w);
                chk("pulse_ready_low", {255'd0, in_ready}, 256'd0);
                chk("pulse_busy", {255'd0, busy}, 256'd1);
            end
        end
    end

    task automatic idle(int n);
        in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(logic [7:0] b, bit gaps);
        bit r;
        int guard;
        if (gaps) idle(int'($urandom_range(0, 3)));
        in_data  = b;
        in_valid = 1;
        guard    = 0;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!r && guard < 2 * TIMEOUT_CYC);
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic send_frame(bit bad, bit gaps);
        logic [7:0]   cs;
        logic [255:0] w;
        cs = 0;
        for (int k = 0; k < 32; k++) begin
            cs ^= pay[k];
            w[8*k +: 8] = pay[k];
        end
        send_byte(SYNC, gaps);
        for (int k = 0; k < 32; k++) send_byte(pay[k], gaps);
        if (!bad) model_w = w;
        q.push_back('{bad, model_w});
        send_byte(bad ? cs ^ 8'h01 : cs, gaps);
    endtask

    task automatic rand_pay();
        for (int k = 0; k < 32; k++) pay[k] = 8'($urandom);
    endtask

    initial begin
        model_w = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, '0);
        chk("reset_flags", {252'd0, in_ready, busy, frame_done, frame_err}, '0);
        reset = 1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {255'd0, in_ready}, 256'd1);

        for (int k = 0; k < 32; k++) pay[k] = 8'h00;
        pay[0] = 8'h44; pay[1] = 8'h33; pay[2] = 8'h22; pay[3] = 8'h11;
        send_frame(0, 0);
        idle(2);
        chk("good_zero0", {224'd0, z0}, 256'h11223344);
        chk("good_rest", outs >> 32, '0);

        send_frame(1, 0);
        idle(2);
        chk("bad_keep_zero0", {224'd0, z0}, 256'h11223344);

        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        idle(2);
        chk("junk_not_busy", {255'd0, busy}, 256'd0);
        for (int k = 0; k < 32; k++) pay[k] = 8'h00;
        pay[28] = 8'hEF; pay[29] = 8'hBE; pay[30] = 8'hAD; pay[31] = 8'hDE;
        send_frame(0, 0);
        idle(2);
        chk("sync_pole3", {224'd0, p3}, 256'hDEADBEEF);
        chk("sync_zero0", {224'd0, z0}, 256'd0);

        rand_pay();
        send_byte(SYNC, 0);
        for (int k = 0; k < 10; k++) send_byte(pay[k], 0);
        idle(TIMEOUT_CYC - 1);
        chk("timeout_not_early", {255'd0, busy}, 256'd1);
        q.push_back('{1'b1, model_w});
        idle(3);
        chk("timeout_hunt", {255'd0, busy}, 256'd0);
        chk("timeout_keep", outs, model_w);
        rand_pay();
        send_frame(0, 0);

        rand_pay();
        send_frame(0, 0);
        rand_pay();
        send_frame(0, 0);
        rand_pay();
        send_frame(0, 1);
        idle(3);
        chk("backpressure_words", outs, model_w);

        rand_pay();
        send_byte(SYNC, 0);
        for (int k = 0; k < 20; k++) send_byte(pay[k], 0);
        reset = 0;
        #1;
        chk("midreset_outs", outs, '0);
        chk("midreset_flags", {252'd0, in_ready, busy, frame_done, frame_err}, '0);
        model_w = '0;
        in_valid = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        rand_pay();
        send_frame(0, 0);
        idle(3);
        chk("after_reset_words", outs, model_w);
        chk("queue_drained", 256'(q.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_assembler.md
Name: frame_assembler

Overview:
- Byte-stream deframer that builds one coefficient frame: 4 zero words and 4 pole words, 32 bits each.
- Input is a valid/ready byte stream from the host link. The block hunts for a sync byte, collects 32 payload bytes, then checks an XOR checksum.
- On a good frame it drives the 8 assembled words and a one-cycle frame_done pulse straight into the downstream frame register, which latches them.
- A bad or stalled frame raises frame_err and leaves the outputs unchanged.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 1024, idle cycles allowed between accepted bytes inside a frame before abort (≥2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  block accepts byte; handshake when in_valid&&in_ready at posedge
zero_in_0..zero_in_3  out  32 each  assembled zero coefficients
pole_in_0..pole_in_3  out  32 each  assembled pole coefficients
frame_done  out  1  one-cycle pulse, good frame; outputs valid in the same cycle
frame_err  out  1  one-cycle pulse, checksum mismatch or timeout
busy  out  1  high whenever state != HUNT

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HUNT; byte counter, timeout counter, checksum accumulator and working buffer cleared.
  - All 8 coefficient outputs = 0; frame_done=0, frame_err=0, busy=0, in_ready=0.
  - in_ready rises on the first clk edge after reset deasserts.
- Frame format, 34 bytes: SYNC_BYTE, then 32 payload bytes, then 1 checksum byte.
  - Payload order is zero_0, zero_1, zero_2, zero_3, pole_0, pole_1, pole_2, pole_3.
  - Each word is sent little-endian: byte k of the payload goes to word k>>2, bits [8*(k&3)+7 : 8*(k&3)].
  - Checksum = XOR of the 32 payload bytes. The sync byte is excluded.
- States:
  - HUNT:
    - in_ready=1.
    - An accepted byte == SYNC_BYTE clears the accumulator and byte counter, then goes to PAYLOAD.
    - Any other accepted byte is discarded silently, with no error.
  - PAYLOAD:
    - in_ready=1.
    - Each accepted byte is written into the working buffer at the counter position, XORed into the accumulator, and the counter increments.
    - The byte accepted at counter=31 moves to CHECK.
    - A payload byte equal to SYNC_BYTE is ordinary data; there is no resync.
  - CHECK:
    - in_ready=1.
    - Accepted byte == accumulator: copy the working buffer into all 8 outputs at that edge and set frame_done=1 for the next cycle.
    - Mismatch: outputs are untouched and frame_err=1 for the next cycle.
    - Either way, go to DONE.
  - DONE:
    - Lasts exactly 1 cycle with in_ready=0; the pulse (frame_done or frame_err) is high during this cycle.
    - Then HUNT.
- Latency: frame_done is high in the cycle immediately after the checksum handshake. The 8 outputs already hold the new values in that cycle and stay stable until the next good frame.
- Outputs never show a partial frame.
- Timeout:
  - Active in PAYLOAD and CHECK; the counter resets on every accepted byte and increments on every other cycle.
  - When the counter reaches TIMEOUT_CYC-1 with no handshake, go to DONE with frame_err=1. Outputs are unchanged.
  - A handshake in the same cycle as the terminal count wins; there is no timeout.
- frame_done and frame_err are never high together, and each is exactly 1 cycle wide.
- in_valid without in_ready (DONE state) is not a handshake. The byte must be held by the source.
- Reset asserted mid-frame aborts immediately to the reset values. There is no frame_err pulse.
- busy=1 in PAYLOAD, CHECK and DONE.

Test Plan:
- Good frame:
  - Stimulus: A5, payload 44 33 22 11 then 28×00, checksum 44.
  - Required: frame_done pulse 1 cycle after the checksum handshake; zero_in_0=32'h11223344; all other words 0; frame_err=0.
- Bad checksum: same frame with checksum 45 -> frame_err pulse, frame_done=0, all outputs keep the previous values.
- Garbage then sync:
  - Stimulus: bytes 00 FF 5A, then a good frame with pole_in_3 = 32'hDEADBEEF (checksum DE^AD^BE^EF = 22).
  - Required: junk is ignored; one frame_done; pole_in_3=32'hDEADBEEF.
- Timeout:
  - Stimulus: A5 plus 10 payload bytes, then in_valid=0 for TIMEOUT_CYC cycles.
  - Required: frame_err pulse, block returns to HUNT (busy=0), outputs unchanged. A following good frame is then accepted.
- Handshake and back-pressure:
  - Stimulus: in_valid held high continuously, with random in_valid gaps inside a frame.
  - Required: in_ready=0 only in the DONE cycle; the byte presented in that cycle is taken one cycle later; the assembled words are correct.
- Reset mid-frame: assert reset after 20 payload bytes -> all outputs 0 and busy=0 immediately, no pulses; a subsequent good frame completes normally.
